// File: rtl/map_bck_ctrl.sv
// map_bck_ctrl: sequencing controller for the backward (beta) recursion of the
// MAP decoder. Walks the beta SRAM from the trellis end (N) down to index 0
// using a read / wait / write cadence per step.
// Optional feature macro: MAP_BCK_LLR_HANDOFF_EN (drives llr_valid/llr_addr
// on every recursion write); when undefined both outputs are tied to 0.
module map_bck_ctrl #(
    parameter int ADDR_W   = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] blk_len,
    output logic [ADDR_W-1:0] bd_addr,
    output logic              w_r_b,
    output logic              init_load,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] step_idx,
    output logic              llr_valid,
    output logic [ADDR_W-1:0] llr_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    // WAIT lasts PIPE_LAT-1 cycles: counter loads PIPE_LAT-2 and exits at 0.
    localparam logic [3:0] WAIT_LOAD = 4'(PIPE_LAT - 2);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t     state;
    logic [3:0] wait_cnt;

    // Main FSM: every output is registered with the value for the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            bd_addr   <= '0;
            w_r_b     <= 1'b0;
            init_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            step_idx  <= '0;
        end else begin
            init_load <= 1'b0;
            done      <= 1'b0;
            if (state != S_IDLE && abort) begin
                state <= S_IDLE;
                w_r_b <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (blk_len == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end else begin
                                state     <= S_INIT;
                                err       <= 1'b0;
                                bd_addr   <= blk_len;
                                w_r_b     <= 1'b1;
                                init_load <= 1'b1;
                                step_idx  <= blk_len;
                            end
                        end
                    end
                    S_INIT: begin
                        state   <= S_READ;
                        bd_addr <= step_idx;
                        w_r_b   <= 1'b0;
                    end
                    S_READ: begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                    S_WAIT: begin
                        if (wait_cnt == '0) begin
                            state   <= S_WRITE;
                            bd_addr <= step_idx - ONE;
                            w_r_b   <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                    S_WRITE: begin
                        w_r_b <= 1'b0;
                        if (step_idx == ONE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_READ;
                            step_idx <= step_idx - ONE;
                            bd_addr  <= step_idx - ONE;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        w_r_b <= 1'b0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef MAP_BCK_LLR_HANDOFF_EN
    logic llr_fire;
    assign llr_fire = (state == S_WAIT) && (wait_cnt == '0) && !abort;

    // Hand each freshly written beta index to the LLR stage, aligned with the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            llr_valid <= 1'b0;
            llr_addr  <= '0;
        end else begin
            llr_valid <= llr_fire;
            if (llr_fire) begin
                llr_addr <= step_idx - ONE;
            end
        end
    end
`else
    assign llr_valid = 1'b0;
    assign llr_addr  = '0;
`endif

endmodule

// File: tb/tb_map_bck_ctrl.sv
`timescale 1ns/1ps
module tb_map_bck_ctrl;

    localparam int AW = 8;
    localparam int PL = 3;
`ifdef MAP_BCK_LLR_HANDOFF_EN
    localparam bit LLR_ON = 1'b1;
`else
    localparam bit LLR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] blk_len;
    logic [AW-1:0] bd_addr, step_idx, llr_addr;
    logic          w_r_b, init_load, busy, done, err, llr_valid;

    map_bck_ctrl #(.ADDR_W(AW), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .blk_len(blk_len),
        .bd_addr(bd_addr), .w_r_b(w_r_b), .init_load(init_load), .busy(busy),
        .done(done), .err(err), .step_idx(step_idx), .llr_valid(llr_valid),
        .llr_addr(llr_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc; int addr; bit wr; bit init; bit dn; bit er; int si; bit lv; int la;
    } ev_t;

    ev_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, expv);
    endtask

    function automatic ev_t mk(int c, int a, bit wr, bit init, bit dn, bit er,
                               int si, bit lv, int la);
        ev_t e;
        e.cyc = c; e.addr = a; e.wr = wr; e.init = init; e.dn = dn; e.er = er;
        e.si = si; e.lv = lv; e.la = la;
        return e;
    endfunction

    // Monitor: any cycle in which the controller shows activity must match the next expected event.
    always @(negedge clk) begin
        ev_t e;
        if (busy || w_r_b || done || init_load || llr_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_activity", {busy, w_r_b, done, init_load, llr_valid}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("w_r_b", w_r_b, e.wr);
                chk("init_load", init_load, e.init);
                chk("done", done, e.dn);
                chk("err", err, e.er);
                chk("busy", busy, 1);
                if (!e.dn) begin
                    chk("bd_addr", bd_addr, e.addr);
                    chk("step_idx", step_idx, e.si);
                end
                chk("llr_valid", llr_valid, e.lv);
                if (e.lv) chk("llr_addr", llr_addr, e.la);
            end
        end
    end

    // One pass: reference trace built from the cadence rules, optionally cut by abort or reset.
    task automatic do_pass(input int n, input int cut_rel, input bit use_rst, input bit noise);
        ev_t evs[$];
        int s, c, endc, cut, stop;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        blk_len = AW'(n);
        if (n == 0) begin
            evs.push_back(mk(s + 1, 0, 0, 0, 1, 1, 0, 0, 0));
        end else begin
            c = s + 1;
            evs.push_back(mk(c, n, 1, 1, 0, 0, n, 0, 0));
            for (int k = n; k >= 1; k--) begin
                for (int w = 0; w < PL; w++) begin
                    c++;
                    evs.push_back(mk(c, k, 0, 0, 0, 0, k, 0, 0));
                end
                c++;
                evs.push_back(mk(c, k - 1, 1, 0, 0, 0, k, LLR_ON, k - 1));
            end
            c++;
            evs.push_back(mk(c, 0, 0, 0, 1, 0, 0, 0, 0));
        end
        endc = evs[$].cyc;
        cut  = (cut_rel > 0) ? s + cut_rel : endc + 100;
        stop = (cut < endc) ? cut : endc;
        foreach (evs[i]) if (evs[i].cyc <= cut) exp_q.push_back(evs[i]);
        while (cyc < stop + 3) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; rst = 1'b0;
            if (cyc == cut) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
            end else if (noise && cyc < stop) begin
                blk_len = AW'($urandom);
                start = (cyc == s + 100) || ($urandom_range(0, 7) == 0);
            end
        end
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        chk("idle_outputs", {busy, w_r_b, done, init_load, llr_valid}, 0);
        if (use_rst && cut_rel > 0)
            chk("reset_midpass_outputs", {bd_addr, err, step_idx, llr_addr}, 0);
    endtask

    initial begin
        int n, len, mode;
        rst = 1'b1; start = 1'b0; abort = 1'b0; blk_len = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset_state",
                {bd_addr, w_r_b, init_load, busy, done, err, step_idx, llr_valid, llr_addr}, 0);
        end

        do_pass(2, 0, 0, 0);
        do_pass(0, 0, 0, 0);
        do_pass(255, 0, 0, 1);
        do_pass(4, 7, 0, 0);
        do_pass(3, 0, 0, 0);
        do_pass(5, 9, 1, 0);
        do_pass(1, 0, 0, 1);

        for (int r = 0; r < 15; r++) begin
            n    = $urandom_range(0, 12);
            len  = (n == 0) ? 1 : 2 + n * (PL + 1);
            mode = $urandom_range(0, 3);
            if (mode == 0) do_pass(n, $urandom_range(1, len), 0, 1);
            else if (mode == 1) do_pass(n, $urandom_range(1, len), 1, 1);
            else do_pass(n, 0, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/map_bck_ctrl.md
# map_bck_ctrl

Sequencing controller for the backward (beta) recursion stage of the MAP decoder. It walks the beta SRAM from the trellis end back to index 0 and drives the stage's `bd_addr` and `w_r_b` inputs. Each step has a read/wait/write cadence so every new beta vector is written only after the adder/compare pipeline has produced it. It sits between the decoder top-level sequencer (start/done handshake) and the backward stage.

## Interface
Parameters:
- `ADDR_W`, 8: width of `bd_addr` and `blk_len`.
- `PIPE_LAT`, 3: cycles from a beta read address being presented to the matching new metrics being valid at the SRAM write port (1 SRAM read, 1 adder, 1 compare). Legal range is 2..15.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a backward pass. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of a running pass.
- `blk_len` in ADDR_W: number of trellis steps N. Latched when `start` is accepted.
- `bd_addr` out ADDR_W: beta SRAM address.
- `w_r_b` out 1: 1 = write, 0 = read.
- `init_load` out 1: one-cycle strobe. Marks the write of the terminal beta vector at address N.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done` out 1: one-cycle pulse at the end of a pass.
- `err` out 1: set together with `done` when N=0. Cleared on the next accepted `start`.
- `step_idx` out ADDR_W: current step index k (counts N..1).
- `llr_valid` out 1: see Configuration.
- `llr_addr` out ADDR_W: see Configuration.

## Operation
FSM states and transitions:
- IDLE → INIT when `start`=1 and N≠0.
- IDLE → DONE when `start`=1 and N=0. This sets `err`.
- INIT: one cycle. `bd_addr`=N, `w_r_b`=1, `init_load`=1. Then k←N, go to READ.
- READ: one cycle. `bd_addr`=k, `w_r_b`=0. Go to WAIT.
- WAIT: PIPE_LAT−1 cycles. `bd_addr` is held at k, `w_r_b`=0. A wait counter counts down to 0, then go to WRITE.
- WRITE: one cycle. `bd_addr`=k−1, `w_r_b`=1.
  - If k=1, go to DONE.
  - Otherwise k←k−1 and go to READ.
- DONE: one cycle. `done`=1. Go to IDLE.

Other rules:
- `abort`=1 in any state other than IDLE forces IDLE on the next edge. No `done` is issued, and the write in that cycle is suppressed (`w_r_b`=0). `abort` has priority over all other transitions.
- `start` while `busy` is ignored. The latched N is unaffected by later `blk_len` changes.
- Recursion steps never overlap, because step k−1 depends on step k.
- All address arithmetic is unsigned ADDR_W. k never goes below 1, so there is no wrap-around.
- Reset values: FSM=IDLE, `bd_addr`=0, `w_r_b`=0, `init_load`=0, `busy`=0, `done`=0, `err`=0, `step_idx`=0, `llr_valid`=0, `llr_addr`=0.
- `rst` asserted mid-pass restores the reset values on the next edge and discards the pass.

## Timing
- All outputs are registered and change one cycle after the state decision.
- Pass length, from the `start` sample edge to the `done` cycle inclusive: 1 + N·(PIPE_LAT+1) + 1 cycles.
- Example with PIPE_LAT=3, N=2 (start sampled at c0):
  - c1: INIT, addr 2.
  - c2: READ, addr 2.
  - c3–c4: WAIT.
  - c5: WRITE, addr 1.
  - c6: READ, addr 1.
  - c7–c8: WAIT.
  - c9: WRITE, addr 0.
  - c10: `done`.
  - c11: `busy`=0. A new `start` is accepted at c11.
- `done` and `busy` are both high in the DONE cycle.

## Configuration
- `MAP_BCK_LLR_HANDOFF_EN` defined:
  - `llr_valid` pulses in every WRITE cycle, with `llr_addr`=k−1. This hands each freshly computed beta index to the LLR stage.
  - Abort suppresses the pulse.
- Not defined: `llr_valid` and `llr_addr` are tied to 0 and the related logic is not compiled.

## Test plan
- Reset, then idle for 5 cycles → all outputs 0. FSM stays in IDLE.
- PIPE_LAT=3, `start` with N=2 → address/w_r_b sequence is exactly (2,W,init)(2,R)(2,R)(2,R)(1,W)(1,R)(1,R)(1,R)(0,W). `done` at cycle 10. `err`=0.
- `start` with N=0 → `done`=1 and `err`=1 one cycle after the sample. No SRAM write occurs.
- N=255 with `start` pulsed again mid-pass → second start ignored. Exactly 255 writes plus 1 init. `done` at cycle 1+255·4+1=1022.
- N=4, `abort` asserted during the second WAIT → IDLE next cycle. No `done`, no further writes, `busy`=0.
- With `MAP_BCK_LLR_HANDOFF_EN`, N=3 → `llr_valid` pulses three times with `llr_addr`=2,1,0, each coincident with `w_r_b`=1.
